// File: rtl/padartha_dispatch_queue.sv
// Dispatch queue: buffers objects in a FIFO and issues them one at a time to a
// classifier, waiting for completion or abandoning the object after TIMEOUT cycles.
// Latency 2 cycles push->object_valid on an idle queue; in_ready low when DEPTH queued.
module padartha_dispatch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [7:0]               in_id,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    object_data,
  output logic [7:0]               object_id,
  output logic                     object_valid,
  input  logic                     classified,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     drop_timeout,
  output logic [15:0]              issued_count,
  output logic [7:0]               timeout_count
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  // Last timer value of a WAIT: the object gets exactly TIMEOUT WAIT cycles.
  localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic [PTR_W-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]        count_q,    count_d;
  logic [15:0]             timer_q,    timer_d;
  logic [DATA_WIDTH-1:0]   obj_data_q, obj_data_d;
  logic [7:0]              obj_id_q,   obj_id_d;
  logic [15:0]             issued_q,   issued_d;
  logic [7:0]              tcnt_q,     tcnt_d;
  logic                    drop_q,     drop_d;

  // Storage is never reset; only pointers and count define what is valid.
  logic [DATA_WIDTH-1:0]   mem_data_q [DEPTH];
  logic [7:0]              mem_id_q   [DEPTH];

  logic                    not_full;
  logic                    push;
  logic                    pop;

  // Full is judged on queued entries only; the in-flight object does not occupy a slot.
  assign not_full = (count_q < DEPTH_C);
  assign push     = !rst && in_valid && not_full;
  assign pop      = !rst && (state_q == ST_IDLE) && (count_q != '0);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Dispatch FSM: pop in IDLE, strobe in ISSUE, wait for completion or timeout in WAIT.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    obj_data_d = obj_data_q;
    obj_id_d   = obj_id_q;
    issued_d   = issued_q;
    tcnt_d     = tcnt_q;
    drop_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          obj_data_d = mem_data_q[rd_ptr_q];
          obj_id_d   = mem_id_q[rd_ptr_q];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // classified is ignored here; the timer starts fresh for the WAIT.
        issued_d = issued_q + 16'd1;
        timer_d  = 16'd0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (classified) begin
          // Completion wins over a coincident timeout.
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Object storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_id_q[wr_ptr_q]   <= in_id;
    end
  end

  // State registers; reset discards queued and in-flight objects without a drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      obj_data_q <= '0;
      obj_id_q   <= '0;
      issued_q   <= '0;
      tcnt_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      obj_data_q <= obj_data_d;
      obj_id_q   <= obj_id_d;
      issued_q   <= issued_d;
      tcnt_q     <= tcnt_d;
      drop_q     <= drop_d;
    end
  end

  // Outputs are forced to their idle values for as long as rst is held.
  assign in_ready      = rst | not_full;
  assign object_valid  = !rst && (state_q == ST_ISSUE);
  assign object_data   = rst ? '0 : obj_data_q;
  assign object_id     = rst ? '0 : obj_id_q;
  assign fifo_count    = rst ? '0 : count_q;
  assign busy          = !rst && ((state_q != ST_IDLE) || (count_q != '0));
  assign drop_timeout  = !rst && drop_q;
  assign issued_count  = rst ? '0 : issued_q;
  assign timeout_count = rst ? '0 : tcnt_q;

  // The issue strobe is never longer than one cycle.
  a_single_issue: assert property (@(posedge clk) disable iff (rst)
    object_valid |=> !object_valid);

  // Occupancy never exceeds the storage.
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= DEPTH_C);

endmodule

// File: doc/padartha_dispatch_queue.md
PADARTHA_DISPATCH_QUEUE -- requirements
Module: padartha_dispatch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, object payload width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; legal values are powers of two from 2 to 64.
REQ-003 SHALL have parameter TIMEOUT, default 63, maximum WAIT cycles allowed per object (1..255).
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  in  DATA_WIDTH  producer object payload.
REQ-007 SHALL have port in_id  in  8  producer object identifier.
REQ-008 SHALL have port in_valid  in  1  producer offers an object.
REQ-009 SHALL have port in_ready  out  1  queue can accept; equals (fifo_count < DEPTH), combinational.
REQ-010 SHALL have port object_data  out  DATA_WIDTH  payload presented to the classifier.
REQ-011 SHALL have port object_id  out  8  identifier presented to the classifier.
REQ-012 SHALL have port object_valid  out  1  single-cycle issue strobe to the classifier.
REQ-013 SHALL have port classified  in  1  classifier completion pulse.
REQ-014 SHALL have port fifo_count  out  $clog2(DEPTH)+1  number of queued entries, excluding the in-flight object.
REQ-015 SHALL have port busy  out  1  high when the FSM is not in IDLE or fifo_count != 0.
REQ-016 SHALL have port drop_timeout  out  1  one-cycle pulse when an in-flight object is abandoned.
REQ-017 SHALL have port issued_count  out  16  objects issued, wrapping from 0xFFFF to 0.
REQ-018 SHALL have port timeout_count  out  8  drops, saturating at 255.

Function
REQ-019 A push SHALL occur when in_valid && in_ready; in_data and in_id are written at the tail.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-022 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-023 In IDLE with fifo_count != 0, the block SHALL pop the head into object_data/object_id and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-024 ISSUE SHALL last exactly one cycle with object_valid=1, then go to WAIT.
REQ-025 object_valid SHALL be 0 in IDLE and WAIT.
REQ-026 object_data and object_id SHALL remain stable from ISSUE until the FSM next pops; the classifier samples them through its analyse and classify stages.
REQ-027 A 16-bit wait timer SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 In WAIT with classified=1, the FSM SHALL go to IDLE; this is a completion.
REQ-029 In WAIT with classified=0 and timer == TIMEOUT-1, the FSM SHALL go to IDLE, pulse drop_timeout in the following cycle, and increment timeout_count.
REQ-030 classified and the timeout condition in the same cycle SHALL count as a completion, with no drop.
REQ-031 classified received in IDLE or ISSUE SHALL be ignored.
REQ-032 issued_count SHALL increment in each ISSUE cycle.
REQ-033 Payload values SHALL be passed through unmodified, including all-zero (absence) objects and 0xF-nibble (atomic) objects.
REQ-034 Latency from a push into an empty, idle queue to object_valid SHALL be 2 cycles: push at edge t, pop at t+1, object_valid high during cycle t+2.
REQ-035 There SHALL be at most one object in flight.

Reset
REQ-036 While rst=1, the FSM SHALL be IDLE and pointers, fifo_count, timer, issued_count and timeout_count SHALL be 0.
REQ-037 While rst=1, object_data, object_id, object_valid and drop_timeout SHALL be 0, busy SHALL be 0 and in_ready SHALL be 1.
REQ-038 Reset asserted mid-WAIT or mid-ISSUE SHALL discard the in-flight object and all queued entries, with no drop_timeout pulse.
REQ-039 FIFO storage SHALL NOT require reset.

Verification
REQ-040 Single push of data=0xD3000001, id=0x05, then classified 4 cycles after object_valid -> object_valid is high for 1 cycle, data is held through WAIT, FSM returns to IDLE, issued_count=1, busy=0.
REQ-041 Back-to-back pushes with classified tied low -> in_ready falls after 9 acceptances (1 in flight + 8 queued), fifo_count=8, and a push while full is refused.
REQ-042 One object issued with no classified, TIMEOUT=63 -> drop_timeout pulses once, timeout_count=1, the next queued object issues in the following cycle.
REQ-043 classified asserted in the same cycle as timer=62 -> completion, drop_timeout stays 0, timeout_count unchanged.
REQ-044 fifo_count=1 in IDLE with a simultaneous push -> one entry pops, one is written, fifo_count stays 1, and pointer wrap is checked after 20 pushes.
REQ-045 rst asserted during WAIT with 3 entries queued -> the next cycle shows fifo_count=0, object_valid=0, no issue after rst deasserts, and no drop pulse.
